// File: rtl/wb_arbiter.sv
// wb_arbiter: single writer of the register-file write port.
// Merges ALU results with FIFO-buffered load/multi-cycle results.
//
// Ports:
//   clk, _reset              clock, async active-low reset
//   alu_valid/dst/data       single-cycle result, no backpressure
//   mem_valid/ready/dst/data variable-latency result handshake
//   wr_sel, wr_data          write port (wr_sel == 0 means no write)
//   alu_hold                 one-cycle request to suppress alu_valid
//   q_sel0/1, q_hit0/1       pending-destination lookups
//   busy                     FIFO non-empty or a write in flight
module wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_dst,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_dst,
  input  logic [31:0] mem_data,
  output logic [4:0]  wr_sel,
  output logic [31:0] wr_data,
  output logic        alu_hold,
  input  logic [4:0]  q_sel0,
  input  logic [4:0]  q_sel1,
  output logic        q_hit0,
  output logic        q_hit1,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] SMAX_M1 = SW'(STARVE_MAX - 1);

  logic [4:0]       dst_q [DEPTH];
  logic [31:0]      dat_q [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic [SW-1:0]    starve;

  logic empty;
  logic alu_fire;
  logic pop;
  logic push;
  logic hold_set;

  assign empty     = (count == '0);
  assign mem_ready = (count < FULL);

  // ALU wins the port unless dropped (dst 0) or held off.
  assign alu_fire = alu_valid && (alu_dst != '0) && !alu_hold;
  assign pop      = !alu_fire && !empty;

  // dst 0 results complete the handshake but never take a slot.
  assign push = mem_valid && mem_ready && (mem_dst != '0);

  // Starve count about to reach the limit on this ALU write.
  assign hold_set = alu_fire && !empty && (starve == SMAX_M1);

  assign busy = !empty || (wr_sel != '0);

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (push) begin
        wr_ptr      <= wr_ptr + 1'b1;
        vld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        vld[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: vld/count decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      dst_q[wr_ptr] <= mem_dst;
      dat_q[wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      wr_sel  <= '0;
      wr_data <= '0;
    end else if (alu_fire) begin
      wr_sel  <= alu_dst;
      wr_data <= alu_data;
    end else if (pop) begin
      wr_sel  <= dst_q[rd_ptr];
      wr_data <= dat_q[rd_ptr];
    end else begin
      wr_sel  <= '0;
    end
  end

  // The hold cycle always pops the head, which clears the counter.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      starve   <= '0;
      alu_hold <= 1'b0;
    end else begin
      alu_hold <= hold_set;
      if (pop || empty) begin
        starve <= '0;
      end else if (alu_fire) begin
        starve <= starve + 1'b1;
      end
    end
  end

  always_comb begin
    q_hit0 = (q_sel0 != '0) && (q_sel0 == wr_sel);
    q_hit1 = (q_sel1 != '0) && (q_sel1 == wr_sel);
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (q_sel0 != '0) && (dst_q[i] == q_sel0)) begin
        q_hit0 = 1'b1;
      end
      if (vld[i] && (q_sel1 != '0) && (dst_q[i] == q_sel1)) begin
        q_hit1 = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and random checks of wb_arbiter
// against a queue-based reference model.
module tb_wb_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        _reset;
  logic        alu_valid;
  logic [4:0]  alu_dst;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_dst;
  logic [31:0] mem_data;
  logic [4:0]  wr_sel;
  logic [31:0] wr_data;
  logic        alu_hold;
  logic [4:0]  q_sel0;
  logic [4:0]  q_sel1;
  logic        q_hit0;
  logic        q_hit1;
  logic        busy;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), ._reset(_reset),
    .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_dst(mem_dst), .mem_data(mem_data),
    .wr_sel(wr_sel), .wr_data(wr_data), .alu_hold(alu_hold),
    .q_sel0(q_sel0), .q_sel1(q_sel1),
    .q_hit0(q_hit0), .q_hit1(q_hit1), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending results in arrival order.
  logic [36:0] mq[$];
  logic [4:0]  m_sel;
  logic [31:0] m_data;
  logic        m_hold;
  int          m_starve;

  function automatic bit m_hit(input logic [4:0] s);
    if (s == 5'd0) return 1'b0;
    if (s == m_sel) return 1'b1;
    foreach (mq[i]) if (mq[i][36:32] == s) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_sel = '0;
    m_data = '0;
    m_hold = 1'b0;
    m_starve = 0;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_dst = '0; alu_data = '0;
    mem_valid = 1'b0; mem_dst = '0; mem_data = '0;
    q_sel0 = '0; q_sel1 = '0;
  endtask

  // One clock: predict from pre-edge inputs, then commit after the edge.
  task automatic step();
    bit ne, fire, pop, push, nh;
    int ns;
    logic [4:0]  nsel;
    logic [31:0] ndata;
    logic [36:0] head, pent;
    ne = (mq.size() != 0);
    fire = alu_valid && (alu_dst != 5'd0) && !m_hold;
    pop = !fire && ne;
    push = mem_valid && (mq.size() < DEPTH) && (mem_dst != 5'd0);
    pent = {mem_dst, mem_data};
    nsel = 5'd0;
    ndata = m_data;
    if (fire) begin
      nsel = alu_dst; ndata = alu_data;
    end else if (pop) begin
      head = mq[0]; nsel = head[36:32]; ndata = head[31:0];
    end
    nh = fire && ne && (m_starve + 1 == STARVE_MAX);
    ns = (pop || !ne) ? 0 : (fire ? m_starve + 1 : m_starve);
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(pent);
    m_sel = nsel; m_data = ndata; m_hold = nh; m_starve = ns;
    #1;
  endtask

  task automatic test_reset();
    idle();
    _reset = 1'b0;
    model_reset();
    #2;
    n_vec++; if (wr_sel !== 5'd0) begin n_err++; $display("FAIL rst_sel: got %0d want 0", wr_sel); end
    n_vec++; if (wr_data !== 32'd0) begin n_err++; $display("FAIL rst_data: got %h want 0", wr_data); end
    n_vec++; if (alu_hold !== 1'b0) begin n_err++; $display("FAIL rst_hold: got %b want 0", alu_hold); end
    n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", mem_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    @(negedge clk);
    _reset = 1'b1;
  endtask

  task automatic test_alu_only();
    alu_valid = 1'b1; alu_dst = 5'd5; alu_data = 32'h12345678;
    step();
    n_vec++; if (wr_sel !== 5'd5) begin n_err++; $display("FAIL alu_sel: got %0d want 5", wr_sel); end
    n_vec++; if (wr_data !== 32'h12345678) begin n_err++; $display("FAIL alu_data: got %h want 12345678", wr_data); end
    alu_valid = 1'b0;
    step();
    n_vec++; if (wr_sel !== 5'd0) begin n_err++; $display("FAIL alu_idle_sel: got %0d want 0", wr_sel); end
    n_vec++; if (wr_data !== 32'h12345678) begin n_err++; $display("FAIL alu_idle_data: got %h want 12345678", wr_data); end
    alu_valid = 1'b1; alu_dst = 5'd0; alu_data = 32'hDEADBEEF;
    step();
    n_vec++; if (wr_sel !== 5'd0) begin n_err++; $display("FAIL alu_dst0_sel: got %0d want 0", wr_sel); end
    n_vec++; if (wr_data !== 32'h12345678) begin n_err++; $display("FAIL alu_dst0_data: got %h want 12345678", wr_data); end
    idle();
  endtask

  task automatic test_fifo_fill();
    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1'b1; alu_dst = 5'(16 + i); alu_data = $urandom;
      mem_valid = 1'b1; mem_dst = 5'(i); mem_data = 32'hA0 + i;
      step();
      n_vec++; if (wr_sel !== 5'(16 + i)) begin n_err++; $display("FAIL fill_alu_sel: got %0d want %0d", wr_sel, 16 + i); end
    end
    mem_valid = 1'b0;
    n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready: got %b want 0", mem_ready); end
    q_sel0 = 5'd3; q_sel1 = 5'd9;
    #1;
    n_vec++; if (q_hit0 !== 1'b1) begin n_err++; $display("FAIL fill_hit3: got %b want 1", q_hit0); end
    n_vec++; if (q_hit1 !== 1'b0) begin n_err++; $display("FAIL fill_hit9: got %b want 0", q_hit1); end
    alu_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      n_vec++; if (wr_sel !== 5'(i)) begin n_err++; $display("FAIL drain_sel: got %0d want %0d", wr_sel, i); end
      n_vec++; if (wr_data !== 32'hA0 + i) begin n_err++; $display("FAIL drain_data: got %h want %h", wr_data, 32'hA0 + i); end
      if (i == 1) begin
        n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL drain_ready: got %b want 1", mem_ready); end
      end
    end
    idle();
  endtask

  task automatic test_starve();
    int first, second;
    first = -1; second = -1;
    alu_valid = 1'b1; alu_dst = 5'd10; alu_data = $urandom;
    mem_valid = 1'b1; mem_dst = 5'd7; mem_data = 32'h77;
    step();
    for (int c = 1; c <= 20; c++) begin
      alu_valid = 1'b1;
      alu_dst = 5'($urandom_range(10, 31));
      alu_data = $urandom;
      mem_valid = (c == 10); mem_dst = 5'd9; mem_data = 32'h99;
      step();
      n_vec++; if (wr_sel !== m_sel) begin n_err++; $display("FAIL starve_sel: got %0d want %0d", wr_sel, m_sel); end
      n_vec++; if (alu_hold !== m_hold) begin n_err++; $display("FAIL starve_hold: got %b want %b", alu_hold, m_hold); end
      if (first > 0 && c == first + 1) begin
        n_vec++; if (wr_sel !== 5'd7) begin n_err++; $display("FAIL starve_head: got %0d want 7", wr_sel); end
      end
      if (alu_hold && first < 0) first = c;
      else if (alu_hold && second < 0 && c > first + 1) second = c;
    end
    n_vec++; if (first != 8) begin n_err++; $display("FAIL starve_first: got %0d want 8", first); end
    n_vec++; if (second != 18) begin n_err++; $display("FAIL starve_restart: got %0d want 18", second); end
    idle();
    step();
  endtask

  task automatic test_full_boundary();
    logic [4:0] want [6];
    int dup;
    want[0] = 5'd11; want[1] = 5'd12; want[2] = 5'd13;
    want[3] = 5'd14; want[4] = 5'd15; want[5] = 5'd0;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_dst = 5'd30; alu_data = $urandom;
      mem_valid = 1'b1; mem_dst = 5'(11 + i); mem_data = $urandom;
      step();
    end
    alu_valid = 1'b0;
    mem_valid = 1'b1; mem_dst = 5'd15; mem_data = 32'h15;
    n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", mem_ready); end
    dup = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) mem_valid = 1'b0;
      step();
      if (wr_sel == 5'd15) dup++;
      n_vec++; if (wr_sel !== want[k]) begin n_err++; $display("FAIL full_seq%0d: got %0d want %0d", k, wr_sel, want[k]); end
      if (k == 0) begin
        q_sel0 = 5'd15;
        #1;
        n_vec++; if (q_hit0 !== 1'b0) begin n_err++; $display("FAIL full_nopush: got %b want 0", q_hit0); end
        n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL full_ready1: got %b want 1", mem_ready); end
      end
    end
    n_vec++; if (dup != 1) begin n_err++; $display("FAIL full_dup: got %0d want 1", dup); end
    idle();
  endtask

  task automatic test_wrap();
    logic [4:0] in_q[$];
    logic [4:0] out_q[$];
    for (int i = 0; i <= 10; i++) begin
      mem_valid = (i < 10);
      mem_dst = 5'($urandom_range(1, 31));
      mem_data = $urandom;
      if (i < 10) in_q.push_back(mem_dst);
      step();
      if (wr_sel != 5'd0) out_q.push_back(wr_sel);
      n_vec++; if (wr_sel !== m_sel) begin n_err++; $display("FAIL wrap_sel: got %0d want %0d", wr_sel, m_sel); end
      n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL wrap_ready: got %b want 1", mem_ready); end
    end
    n_vec++; if (out_q.size() != 10) begin n_err++; $display("FAIL wrap_len: got %0d want 10", out_q.size()); end
    for (int i = 0; i < 10 && i < out_q.size(); i++) begin
      n_vec++; if (out_q[i] !== in_q[i]) begin n_err++; $display("FAIL wrap_order%0d: got %0d want %0d", i, out_q[i], in_q[i]); end
    end
    idle();
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_dst = 5'd29; alu_data = $urandom;
      mem_valid = 1'b1; mem_dst = 5'(21 + i); mem_data = $urandom;
      step();
    end
    idle();
    #2;
    _reset = 1'b0;
    model_reset();
    #1;
    n_vec++; if (wr_sel !== 5'd0) begin n_err++; $display("FAIL mrst_sel: got %0d want 0", wr_sel); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mrst_busy: got %b want 0", busy); end
    n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL mrst_ready: got %b want 1", mem_ready); end
    for (int s = 21; s <= 29; s += 2) begin
      q_sel0 = 5'(s);
      #1;
      n_vec++; if (q_hit0 !== 1'b0) begin n_err++; $display("FAIL mrst_hit%0d: got %b want 0", s, q_hit0); end
    end
    @(negedge clk);
    _reset = 1'b1;
    q_sel0 = '0;
    step();
    n_vec++; if (wr_sel !== 5'd0) begin n_err++; $display("FAIL mrst_after: got %0d want 0", wr_sel); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      alu_valid = ($urandom_range(0, 99) < ((c < 200) ? 85 : 50));
      alu_dst = 5'($urandom_range(0, 31));
      alu_data = $urandom;
      mem_valid = ($urandom_range(0, 99) < 50);
      mem_dst = 5'($urandom_range(0, 31));
      mem_data = $urandom;
      q_sel0 = 5'($urandom_range(0, 31));
      q_sel1 = 5'($urandom_range(0, 31));
      #1;
      n_vec++; if (q_hit0 !== m_hit(q_sel0)) begin n_err++; $display("FAIL rnd_hit0: sel %0d got %b want %b", q_sel0, q_hit0, m_hit(q_sel0)); end
      n_vec++; if (q_hit1 !== m_hit(q_sel1)) begin n_err++; $display("FAIL rnd_hit1: sel %0d got %b want %b", q_sel1, q_hit1, m_hit(q_sel1)); end
      n_vec++; if (mem_ready !== (mq.size() < DEPTH)) begin n_err++; $display("FAIL rnd_ready: got %b want %b", mem_ready, mq.size() < DEPTH); end
      n_vec++; if (busy !== (mq.size() != 0 || m_sel != 5'd0)) begin n_err++; $display("FAIL rnd_busy: got %b", busy); end
      step();
      n_vec++; if (wr_sel !== m_sel) begin n_err++; $display("FAIL rnd_sel: got %0d want %0d", wr_sel, m_sel); end
      n_vec++; if (wr_data !== m_data) begin n_err++; $display("FAIL rnd_data: got %h want %h", wr_data, m_data); end
      n_vec++; if (alu_hold !== m_hold) begin n_err++; $display("FAIL rnd_hold: got %b want %b", alu_hold, m_hold); end
    end
    idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu_only();
    test_fifo_fill();
    test_starve();
    test_full_boundary();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-side driver of the register-file write port: the single producer of the write select and write data that the register file consumes.
- Merges single-cycle ALU results with variable-latency load/multi-cycle results.
- Buffers load results in a small FIFO and issues at most one register write per cycle.
- Exposes pending-destination lookups so the issue stage can stall on RAW/WAW hazards.

Parameters:
- DEPTH, 4, load-result FIFO entries (power of 2, >=2).
- STARVE_MAX, 8, consecutive cycles of ALU writes allowed while the FIFO is non-empty before alu_hold is asserted.

Ports:
- clk  in  1  clock; all state updates on posedge.
- _reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result valid this cycle; no backpressure.
- alu_dst  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- mem_valid  in  1  load/multi-cycle result offered.
- mem_ready  out  1  FIFO can accept a mem result.
- mem_dst  in  5  mem destination register.
- mem_data  in  32  mem result.
- wr_sel  out  5  register-file write select; 0 = no write.
- wr_data  out  32  register-file write data.
- alu_hold  out  1  request to the pipeline to suppress alu_valid next cycle.
- q_sel0, q_sel1  in  5 each  pending-destination queries.
- q_hit0, q_hit1  out  1 each  queried register has a pending write.
- busy  out  1  FIFO non-empty or wr_sel != 0.

Behaviour:
- Reset (async, _reset=0):
  - FIFO emptied, count=0.
  - wr_sel=0, wr_data=0, alu_hold=0, starve counter=0.
  - mem_ready=1 once the FIFO is empty.
  - Reset mid-operation discards all buffered results.
- Accept rules:
  - mem handshake completes when mem_valid && mem_ready at posedge.
  - mem_ready = (count < DEPTH), combinational from registered count only; no same-cycle push-through when full.
  - mem_dst=0 is accepted and discarded without occupying a slot.
- Issue priority, evaluated each posedge:
  - (1) alu_valid && alu_dst!=0 && !alu_hold → wr_sel<=alu_dst, wr_data<=alu_data.
  - (2) else FIFO non-empty → pop head, wr_sel<=head dst, wr_data<=head data.
  - (3) else wr_sel<=0; wr_data holds its value.
  - alu_valid with alu_dst=0 is dropped and leaves the slot free for the FIFO.
- Latency:
  - Write appears on wr_sel/wr_data exactly 1 cycle after acceptance for ALU results.
  - Write appears >=1 cycle after acceptance for mem results.
  - Each write is held one full cycle; the register file captures it on the following negedge.
- Simultaneous push and pop: count unchanged; FIFO order strictly preserved, no reordering.
- Pointers: log2(DEPTH)-bit read/write pointers, wrap-around modulo DEPTH; count is log2(DEPTH)+1 bits.
- Starvation control:
  - Counter increments each cycle an ALU write is issued while the FIFO is non-empty.
  - Counter clears when a FIFO pop occurs or the FIFO is empty.
  - On reaching STARVE_MAX: alu_hold=1 for exactly one cycle (registered).
  - During that cycle the FIFO head is issued even if alu_valid=1. An alu_valid asserted while alu_hold=1 is a protocol error; the ALU result is dropped.
  - Counter clears after the hold cycle.
- Hazard lookup (combinational):
  - q_hitN=1 iff q_selN!=0 and q_selN matches any valid FIFO entry dst or the current wr_sel.
  - q_selN=0 → q_hitN=0.
  - The issue stage stalls on q_hit; this block provides no data forwarding.
- WAW ordering between ALU and mem results to the same register is guaranteed by the issue stage stalling on q_hit. This block never compares ALU and FIFO destinations.

Test Plan:
- Reset check: assert _reset=0 mid-stream with 3 entries buffered → immediately wr_sel=0, busy=0, mem_ready=1, q_hit0=0 for any sel.
- ALU only: alu_valid, dst=5, data=0x12345678 → next cycle wr_sel=5, wr_data=0x12345678; following idle cycle wr_sel=0. alu_dst=0 produces no write.
- Mem FIFO fill: push mem dst 1..4 with data 0xA1..0xA4 while ALU writes every cycle → mem_ready=0 after 4th push; q_sel0=3 gives q_hit0=1; once ALU stops, writes drain in order 1,2,3,4 on consecutive cycles and mem_ready returns to 1 after the first pop.
- Starvation: FIFO holds dst=7, ALU valid every cycle with STARVE_MAX=8 → alu_hold=1 on cycle 8; that cycle wr_sel=7; the counter restarts afterward.
- Full boundary: count=DEPTH with a pop and mem_valid in the same cycle → no push that cycle (mem_ready was 0); push succeeds next cycle; no data lost or duplicated.
- Wrap-around: 10 sequential push/pop pairs with DEPTH=4 → output dst sequence identical to input; count never exceeds 4.
